// File: rtl/bcd_pkg.sv
// Shared types for the sequential binary-to-BCD converter.
//   bcd_t    : one packed BCD digit
//   state_t  : converter FSM states
//   BCD_NINE : digit value used when saturating on overflow
package bcd_pkg;
    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam bcd_t BCD_NINE = 4'd9;
endpackage

// File: rtl/conversor_bin_bcd_if.sv
// Handshake/result bundle of the binary-to-BCD converter.
//   start/numero : conversion request (driven by the master)
//   ready/valid  : accept window / one-cycle result strobe
//   digits, negativo, overflow, blank : registered result
interface conversor_bin_bcd_if #(
    parameter int WIDTH    = 32,
    parameter int N_DIGITS = 6
) ();
    logic                    start;
    logic [WIDTH-1:0]        numero;
    logic                    ready;
    logic                    valid;
    logic [4*N_DIGITS-1:0]   digits;
    logic                    negativo;
    logic                    overflow;
    logic [N_DIGITS-1:0]     blank;

    modport master (
        output start, numero,
        input  ready, valid, digits, negativo, overflow, blank
    );

    modport slave (
        input  start, numero,
        output ready, valid, digits, negativo, overflow, blank
    );
endinterface

// File: rtl/ajuste_bcd.sv
// Double-dabble digit correction: digits >= 5 get +3 so that the following
// left shift carries correctly into the next decimal digit.
//   din  : BCD digit before the shift
//   dout : corrected digit
module ajuste_bcd
    import bcd_pkg::*;
(
    input  bcd_t din,
    output bcd_t dout
);
    assign dout = (din >= 4'd5) ? bcd_t'(din + 4'd3) : din;
endmodule

// File: rtl/conversor_bin_bcd.sv
// Iterative binary-to-BCD converter (double dabble, one bit per clock).
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   conv       : start/numero request, ready/valid handshake and the
//                registered result (digits, negativo, overflow, blank)
// A conversion takes WIDTH shift cycles plus one DONE cycle; the result
// registers only change in DONE and hold until the next conversion ends.
module conversor_bin_bcd
    import bcd_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_DIGITS = 6,
    parameter int SIGNED   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    conversor_bin_bcd_if.slave   conv
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * N_DIGITS;
    localparam logic [N_DIGITS-1:0] BLANK_RST = {N_DIGITS{1'b1}} << 1;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  sr;
    logic [WIDTH-1:0]  mag;
    logic [BW-1:0]     acc, acc_adj;
    logic [CW-1:0]     cnt;
    logic              sign_q, ovf_q;

    logic              valid_q, neg_q, ovf_out_q;
    logic [BW-1:0]     digits_q;
    logic [N_DIGITS-1:0] blank_q, blank_c;

    // Magnitude is WIDTH bits unsigned, so negating -2^(WIDTH-1) is exact.
    always_comb begin
        mag = conv.numero;
        if (SIGNED != 0 && conv.numero[WIDTH-1])
            mag = ~conv.numero + WIDTH'(1);
    end

    genvar g;
    generate
        for (g = 0; g < N_DIGITS; g++) begin : g_adj
            ajuste_bcd u_adj (
                .din  (acc[4*g +: 4]),
                .dout (acc_adj[4*g +: 4])
            );
        end
    endgenerate

    // Leading-zero mask, scanned from the most-significant digit down.
    always_comb begin
        logic allz;
        allz    = 1'b1;
        blank_c = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            allz       = allz & (acc[4*k +: 4] == 4'd0);
            blank_c[k] = allz;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (conv.start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr        <= '0;
            acc       <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            digits_q  <= '0;
            neg_q     <= 1'b0;
            ovf_out_q <= 1'b0;
            blank_q   <= BLANK_RST;
        end else begin
            valid_q <= (state == DONE);
            case (state)
                IDLE: if (conv.start) begin
                    sr     <= mag;
                    acc    <= '0;
                    ovf_q  <= 1'b0;
                    cnt    <= CW'(WIDTH);
                    sign_q <= (SIGNED != 0) && conv.numero[WIDTH-1] && (mag != '0);
                end
                SHIFT: begin
                    acc   <= {acc_adj[BW-2:0], sr[WIDTH-1]};
                    sr    <= sr << 1;
                    // A set MSB leaving the accumulator means a decimal carry
                    // beyond the top digit.
                    ovf_q <= ovf_q | acc_adj[BW-1];
                    cnt   <= cnt - CW'(1);
                end
                DONE: begin
                    neg_q     <= sign_q;
                    ovf_out_q <= ovf_q;
                    if (ovf_q) begin
                        digits_q <= {N_DIGITS{BCD_NINE}};
                        blank_q  <= '0;
                    end else begin
                        digits_q <= acc;
                        blank_q  <= blank_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign conv.ready    = (state == IDLE);
    assign conv.valid    = valid_q;
    assign conv.digits   = digits_q;
    assign conv.negativo = neg_q;
    assign conv.overflow = ovf_out_q;
    assign conv.blank    = blank_q;
endmodule

// File: tb/tb_conversor_bin_bcd.sv
module tb_conversor_bin_bcd;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conversor_bin_bcd_if #(.WIDTH(32), .N_DIGITS(6))  if0 ();
    conversor_bin_bcd_if #(.WIDTH(32), .N_DIGITS(10)) if1 ();

    conversor_bin_bcd #(.WIDTH(32), .N_DIGITS(6), .SIGNED(0)) dut0 (
        .clk(clk), .reset(reset), .conv(if0));
    conversor_bin_bcd #(.WIDTH(32), .N_DIGITS(10), .SIGNED(1)) dut1 (
        .clk(clk), .reset(reset), .conv(if1));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Unsigned 6-digit instance: request and wait for valid.
    task automatic run0(input logic [31:0] n, output int lat);
        int w;
        lat = -1;
        w = 0;
        while (!if0.ready && w < 100) begin @(posedge clk); #1; w++; end
        @(negedge clk);
        if0.start = 1'b1; if0.numero = n;
        @(posedge clk); #1;
        if0.start = 1'b0; if0.numero = 32'hDEAD_BEEF;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (if0.valid) begin lat = c; break; end
        end
    endtask

    task automatic run1(input logic [31:0] n, output int lat);
        int w;
        lat = -1;
        w = 0;
        while (!if1.ready && w < 100) begin @(posedge clk); #1; w++; end
        @(negedge clk);
        if1.start = 1'b1; if1.numero = n;
        @(posedge clk); #1;
        if1.start = 1'b0; if1.numero = 32'h1234_5678;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (if1.valid) begin lat = c; break; end
        end
    endtask

    typedef struct {
        logic [31:0] n;
        logic [23:0] d;
        logic        ovf;
        logic [5:0]  blk;
    } vec0_t;

    typedef struct {
        logic [31:0] n;
        logic [39:0] d;
        logic        neg;
        logic [9:0]  blk;
    } vec1_t;

    vec0_t t0[9];
    vec1_t t1[4];

    initial begin
        int lat, nval, lastv, lowrun, badrun;
        t0[0] = '{32'd123456,     24'h123456, 1'b0, 6'b000000};
        t0[1] = '{32'd0,          24'h000000, 1'b0, 6'b111110};
        t0[2] = '{32'd7,          24'h000007, 1'b0, 6'b111110};
        t0[3] = '{32'd1000,       24'h001000, 1'b0, 6'b110000};
        t0[4] = '{32'd1000000,    24'h999999, 1'b1, 6'b000000};
        t0[5] = '{32'd5,          24'h000005, 1'b0, 6'b111110};
        t0[6] = '{32'd999999,     24'h999999, 1'b0, 6'b000000};
        t0[7] = '{32'hFFFF_FFFF,  24'h999999, 1'b1, 6'b000000};
        t0[8] = '{32'd99,         24'h000099, 1'b0, 6'b111100};

        t1[0] = '{-32'sd42,       40'h0000000042, 1'b1, 10'b1111111100};
        t1[1] = '{32'h8000_0000,  40'h2147483648, 1'b1, 10'b0000000000};
        t1[2] = '{32'd42,         40'h0000000042, 1'b0, 10'b1111111100};
        t1[3] = '{32'd0,          40'h0000000000, 1'b0, 10'b1111111110};

        if0.start = 1'b0; if0.numero = '0;
        if1.start = 1'b0; if1.numero = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  64'(if0.ready),    64'd1);
        chk("rst_valid",  64'(if0.valid),    64'd0);
        chk("rst_digits", 64'(if0.digits),   64'd0);
        chk("rst_neg",    64'(if0.negativo), 64'd0);
        chk("rst_ovf",    64'(if0.overflow), 64'd0);
        chk("rst_blank",  64'(if0.blank),    64'b111110);
        @(negedge clk); reset = 1'b0;

        foreach (t0[i]) begin
            run0(t0[i].n, lat);
            chk($sformatf("u%0d_lat", i),    64'(lat),          64'd33);
            chk($sformatf("u%0d_digits", i), 64'(if0.digits),   64'(t0[i].d));
            chk($sformatf("u%0d_ovf", i),    64'(if0.overflow), 64'(t0[i].ovf));
            chk($sformatf("u%0d_blank", i),  64'(if0.blank),    64'(t0[i].blk));
            chk($sformatf("u%0d_neg", i),    64'(if0.negativo), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("u%0d_vpulse", i), 64'(if0.valid),    64'd0);
        end

        foreach (t1[i]) begin
            run1(t1[i].n, lat);
            chk($sformatf("s%0d_lat", i),    64'(lat),          64'd33);
            chk($sformatf("s%0d_digits", i), 64'(if1.digits),   64'(t1[i].d));
            chk($sformatf("s%0d_neg", i),    64'(if1.negativo), 64'(t1[i].neg));
            chk($sformatf("s%0d_ovf", i),    64'(if1.overflow), 64'd0);
            chk($sformatf("s%0d_blank", i),  64'(if1.blank),    64'(t1[i].blk));
        end

        // Start held high: 33 busy cycles, one valid every 34 cycles.
        @(negedge clk);
        if0.start = 1'b1; if0.numero = 32'd12;
        @(posedge clk); #1;
        nval = 0; lastv = -1; lowrun = 0; badrun = 0;
        for (int c = 1; c <= 136; c++) begin
            if (!if0.ready) lowrun++;
            else begin
                if (lowrun != 33) badrun++;
                lowrun = 0;
            end
            @(posedge clk); #1;
            if (if0.valid) begin nval++; lastv = c; end
        end
        if0.start = 1'b0;
        chk("held_nvalid",  64'(nval),  64'd4);
        chk("held_lastv",   64'(lastv), 64'd135);
        chk("held_busyrun", 64'(badrun), 64'd0);
        chk("held_digits",  64'(if0.digits), 64'h000012);
        repeat (40) @(posedge clk);

        // Start during SHIFT with another value is ignored, not queued.
        @(negedge clk);
        if0.start = 1'b1; if0.numero = 32'd123;
        @(negedge clk);
        if0.start = 1'b0; if0.numero = '0;
        repeat (4) @(negedge clk);
        if0.start = 1'b1; if0.numero = 32'd999;
        @(negedge clk);
        if0.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (if0.valid) begin lat = c; break; end
        end
        chk("ign_seen",   64'(lat != -1),  64'd1);
        chk("ign_digits", 64'(if0.digits), 64'h000123);
        repeat (2) @(posedge clk);
        #1;
        chk("ign_noqueue_ready", 64'(if0.ready), 64'd1);
        nval = 0;
        repeat (40) begin @(posedge clk); #1; if (if0.valid) nval++; end
        chk("ign_noqueue_valid", 64'(nval), 64'd0);

        // Reset at cycle 10 of a conversion aborts it.
        @(negedge clk);
        if0.start = 1'b1; if0.numero = 32'd555;
        @(posedge clk); #1;
        if0.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_ready",  64'(if0.ready),  64'd1);
        chk("abort_digits", 64'(if0.digits), 64'd0);
        chk("abort_blank",  64'(if0.blank),  64'b111110);
        chk("abort_valid",  64'(if0.valid),  64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        nval = 0;
        repeat (40) begin @(posedge clk); #1; if (if0.valid) nval++; end
        chk("abort_novalid", 64'(nval), 64'd0);
        run0(32'd321, lat);
        chk("after_lat",    64'(lat),        64'd33);
        chk("after_digits", 64'(if0.digits), 64'h000321);
        chk("after_blank",  64'(if0.blank),  64'b111000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conversor_bin_bcd.md
Name: conversor_bin_bcd

Overview:
Parametrised sequential binary-to-BCD converter using the iterative double-dabble method, one input bit per clock. Replaces the purely combinational divide/modulo digit split, which does not close timing at wide input widths. It feeds the 7-segment and display drivers with a start/valid handshake. Adds optional signed input, overflow saturation and a leading-zero blanking mask.

Parameters:
WIDTH, 32, input word width in bits (>=4).
N_DIGITS, 6, number of BCD output digits (1..10).
SIGNED, 0, 1 = input is two's complement; 0 = unsigned.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  request a conversion; sampled only when ready=1.
numero  in  WIDTH  value to convert; sampled in the same cycle as an accepted start.
ready  out  1  high in IDLE; a conversion can be accepted.
valid  out  1  one-cycle pulse: result outputs updated.
digits  out  4*N_DIGITS  packed BCD; digit k at [4k+3:4k], digit 0 is the units digit.
negativo  out  1  input was negative (always 0 when SIGNED=0).
overflow  out  1  magnitude >= 10^N_DIGITS.
blank  out  N_DIGITS  bit k=1 when digit k is a leading zero; bit 0 is always 0.

Behaviour:
- Reset, asynchronous: state=IDLE, ready=1, valid=0, digits=0, negativo=0, overflow=0, blank={N_DIGITS-1 ones, 0}. Reset asserted mid-conversion aborts the conversion immediately and produces no valid pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on start=1, latch the magnitude into the shift register. The magnitude is numero, or its two's-complement negation when SIGNED=1 and the MSB is 1. Magnitude width is WIDTH unsigned, so -2^(WIDTH-1) is handled correctly. Also latch the sign, clear the BCD accumulator and the sticky overflow bit, load bit counter=WIDTH, and go to SHIFT.
- SHIFT, once per cycle:
  - For every digit >=5, add 3.
  - Shift {BCD accumulator, shift register} left by 1.
  - If bit 3 of the top digit was 1 before the shift, set sticky overflow.
  - Decrement the counter; after the WIDTH-th shift, go to DONE.
- DONE, one cycle:
  - Register the outputs and pulse valid=1.
  - If overflow, digits is forced to all 9s and blank to 0.
  - Otherwise, blank is computed from the most-significant digit downward: bit k=1 while digit k and all higher digits are 0 (k>=1).
  - negativo = latched sign AND (magnitude != 0).
  - Next state is IDLE.
- ready is 1 only in IDLE. A start in SHIFT or DONE is ignored and not queued. numero is don't-care outside the accepting cycle.
- Latency: start accepted at edge 0 -> valid=1 in cycle WIDTH+1. Back-to-back throughput is one result per WIDTH+2 cycles.
- Result outputs hold their value until the next DONE; they are not cleared on start.
- Counter width is $clog2(WIDTH+1). No combinational path from inputs to outputs.

Decomposition:
- Shared package bcd_pkg:
  - BCD digit typedef (4 bits).
  - FSM state enum {IDLE, SHIFT, DONE}.
  - Constant BCD_NINE = 4'd9.
- Sub-module ajuste_bcd: one combinational digit corrector (in>=5 ? in+3 : in), instantiated N_DIGITS times via generate.

Test Plan:
- WIDTH=32, N_DIGITS=6, numero=123456, start pulse -> valid at cycle 33, digits=0x123456, overflow=0, blank=000000, negativo=0.
- numero=0 -> digits=0x000000, blank=111110. Then numero=7 -> digits=0x000007, blank=111110. Then numero=1000 -> blank=110000.
- numero=1000000 -> overflow=1, digits=0x999999, blank=0. Next conversion of 5 -> overflow=0, digits=0x000005.
- SIGNED=1: numero=-42 -> negativo=1, digits=0x000042. numero=-2^31 with N_DIGITS=10 -> digits=2147483648, negativo=1, overflow=0.
- Start held high continuously -> ready low for 33 cycles, exactly one valid per 34 cycles. A start asserted in SHIFT with a different numero does not alter the current result.
- Assert reset at cycle 10 of a conversion -> ready=1, digits=0 immediately, no valid pulse. A fresh start after release converts correctly.
